// File: rtl/k_and_s_pkg.sv
// Shared K&S types: decoded instruction, control FSM states and ALU op codes.
package k_and_s_pkg;

   typedef enum logic [4:0] {
      I_NOP    = 5'd0,
      I_LOAD   = 5'd1,
      I_STORE  = 5'd2,
      I_MOVE   = 5'd3,
      I_ADD    = 5'd4,
      I_SUB    = 5'd5,
      I_AND    = 5'd6,
      I_OR     = 5'd7,
      I_BRANCH = 5'd8,
      I_BZERO  = 5'd9,
      I_BNZERO = 5'd10,
      I_BNEG   = 5'd11,
      I_BNNEG  = 5'd12,
      I_BOV    = 5'd13,
      I_BNOV   = 5'd14,
      I_HALT   = 5'd15
   } decoded_instruction_type;

   typedef enum logic [2:0] {
      StFetch,
      StFetchIr,
      StDecode,
      StLoadAddr,
      StLoadWb,
      StStore,
      StExec,
      StHalt
   } ctrl_state_t;

   localparam logic [1:0] OP_OR  = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   // Condition of a branch-group instruction; 0 for anything outside the group.
   function automatic logic branch_cond(decoded_instruction_type instr, logic zero,
                                        logic neg, logic sov);
      logic taken;
      taken = 1'b0;
      case (instr)
         I_BRANCH: taken = 1'b1;
         I_BZERO:  taken = zero;
         I_BNZERO: taken = !zero;
         I_BNEG:   taken = neg;
         I_BNNEG:  taken = !neg;
         I_BOV:    taken = sov;
         I_BNOV:   taken = !sov;
         default:  taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/control_unit.sv
// K&S processor control FSM: fetch/decode/execute strobes for the datapath.
// Optional CONTROL_UNIT_PERF_EN adds cycle_count/instr_count performance counters.
module control_unit
   import k_and_s_pkg::*;
#(
   parameter int unsigned PERF_CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
`ifdef CONTROL_UNIT_PERF_EN
   output logic [PERF_CNT_W-1:0]   cycle_count,
   output logic [PERF_CNT_W-1:0]   instr_count,
`endif
   output logic                    halt
);

   ctrl_state_t state_q, state_d;

   // No branch condition tests unsigned overflow.
   logic unused_flag;
   assign unused_flag = unsigned_overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = OP_OR;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;
      // Outputs are gated by rst so a reset mid-instruction emits no strobes.
      if (!rst) begin
         unique case (state_q)
            StFetch: begin
               addr_sel = 1'b1;
               state_d  = StFetchIr;
            end
            StFetchIr: begin
               addr_sel  = 1'b1;
               ir_enable = 1'b1;
               state_d   = StDecode;
            end
            StDecode: begin
               if (decoded_instruction == I_HALT) begin
                  state_d = StHalt;
               end else begin
                  pc_enable = 1'b1;
                  branch    = branch_cond(decoded_instruction, zero_op, neg_op,
                                          signed_overflow);
                  case (decoded_instruction)
                     I_LOAD:                             state_d = StLoadAddr;
                     I_STORE:                            state_d = StStore;
                     I_ADD, I_SUB, I_AND, I_OR, I_MOVE:  state_d = StExec;
                     default:                            state_d = StFetch;
                  endcase
               end
            end
            StLoadAddr: begin
               state_d = StLoadWb;
            end
            StLoadWb: begin
               write_reg_enable = 1'b1;
               state_d          = StFetch;
            end
            StStore: begin
               ram_write_enable = 1'b1;
               state_d          = StFetch;
            end
            StExec: begin
               c_sel            = 1'b1;
               write_reg_enable = 1'b1;
               flags_reg_enable = 1'b1;
               case (decoded_instruction)
                  I_ADD:   operation = OP_ADD;
                  I_SUB:   operation = OP_SUB;
                  I_AND:   operation = OP_AND;
                  I_OR:    operation = OP_OR;
                  default: begin
                     // MOVE passes A through as A|A and leaves the flags alone.
                     operation        = OP_OR;
                     flags_reg_enable = 1'b0;
                  end
               endcase
               state_d = StFetch;
            end
            StHalt: begin
               halt = 1'b1;
            end
         endcase
      end
   end

`ifdef CONTROL_UNIT_PERF_EN
   logic [PERF_CNT_W-1:0] cycle_q, instr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         if (state_q != StHalt) begin
            cycle_q <= cycle_q + PERF_CNT_W'(1);
         end
         if (state_q == StDecode && decoded_instruction != I_HALT) begin
            instr_q <= instr_q + PERF_CNT_W'(1);
         end
      end
   end

   assign cycle_count = cycle_q;
   assign instr_count = instr_q;
`else
   logic [PERF_CNT_W-1:0] unused_perf;
   assign unused_perf = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against an instruction-step model.
module tb_control_unit;
   import k_and_s_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   decoded_instruction_type decoded_instruction = I_NOP;
   logic zero_op = 1'b0, neg_op = 1'b0, unsigned_overflow = 1'b0, signed_overflow = 1'b0;
   logic branch, pc_enable, ir_enable, addr_sel, c_sel;
   logic [1:0] operation;
   logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;
`ifdef CONTROL_UNIT_PERF_EN
   logic [15:0] cycle_count, instr_count;
`endif

   control_unit #(.PERF_CNT_W(16)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .decoded_instruction (decoded_instruction),
      .zero_op             (zero_op),
      .neg_op              (neg_op),
      .unsigned_overflow   (unsigned_overflow),
      .signed_overflow     (signed_overflow),
      .branch              (branch),
      .pc_enable           (pc_enable),
      .ir_enable           (ir_enable),
      .addr_sel            (addr_sel),
      .c_sel               (c_sel),
      .operation           (operation),
      .write_reg_enable    (write_reg_enable),
      .flags_reg_enable    (flags_reg_enable),
      .ram_write_enable    (ram_write_enable),
`ifdef CONTROL_UNIT_PERF_EN
      .cycle_count         (cycle_count),
      .instr_count         (instr_count),
`endif
      .halt                (halt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: position within the current instruction (0 = first fetch cycle).
   int step = 0;
   bit halted = 1'b0;
   decoded_instruction_type cur = I_NOP;
   int exp_cyc = 0;
   int exp_ins = 0;

   logic nx_rst = 1'b1;
   decoded_instruction_type nx_instr = I_NOP;
   logic nx_z = 1'b0, nx_n = 1'b0, nx_u = 1'b0, nx_s = 1'b0;

   function automatic int instr_len(decoded_instruction_type i);
      case (i)
         I_LOAD:                                      return 5;
         I_STORE, I_ADD, I_SUB, I_AND, I_OR, I_MOVE:  return 4;
         default:                                     return 3;
      endcase
   endfunction

   function automatic bit taken(decoded_instruction_type i, bit z, bit n, bit s);
      case (i)
         I_BRANCH: return 1'b1;
         I_BZERO:  return z;
         I_BNZERO: return !z;
         I_BNEG:   return n;
         I_BNNEG:  return !n;
         I_BOV:    return s;
         I_BNOV:   return !s;
         default:  return 1'b0;
      endcase
   endfunction

   function automatic bit is_alu(decoded_instruction_type i);
      return i inside {I_ADD, I_SUB, I_AND, I_OR, I_MOVE};
   endfunction

   // {branch, pc_en, ir_en, addr_sel, c_sel, op[1:0], wr_reg, flags_en, ram_we, halt}
   function automatic logic [10:0] model_out();
      logic br, pce, ire, as, cs, wre, fre, rwe, hl;
      logic [1:0] op;
      {br, pce, ire, as, cs, wre, fre, rwe, hl} = '0;
      op = 2'd0;
      if (rst) begin
      end else if (halted) begin
         hl = 1'b1;
      end else if (step == 0) begin
         as = 1'b1;
      end else if (step == 1) begin
         as  = 1'b1;
         ire = 1'b1;
      end else if (step == 2) begin
         if (decoded_instruction != I_HALT) begin
            pce = 1'b1;
            br  = taken(decoded_instruction, zero_op, neg_op, signed_overflow);
         end
      end else if (step == 3) begin
         if (cur == I_STORE) rwe = 1'b1;
         if (is_alu(cur)) begin
            cs  = 1'b1;
            wre = 1'b1;
            fre = (cur != I_MOVE);
            op  = (cur == I_ADD) ? 2'd1 : (cur == I_SUB) ? 2'd2 : (cur == I_AND) ? 2'd3 : 2'd0;
         end
      end else begin
         wre = 1'b1;
      end
      return {br, pce, ire, as, cs, op, wre, fre, rwe, hl};
   endfunction

   task automatic check_cycle();
      logic [10:0] got, want;
      got  = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
              write_reg_enable, flags_reg_enable, ram_write_enable, halt};
      want = model_out();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL outputs t=%0t step=%0d instr=%0d got %b want %b",
                  $time, step, decoded_instruction, got, want);
      end
`ifdef CONTROL_UNIT_PERF_EN
      if (!rst) begin
         checks++;
         if (cycle_count !== 16'(exp_cyc) || instr_count !== 16'(exp_ins)) begin
            errors++;
            $display("FAIL perf_counters got cyc=%0d ins=%0d want cyc=%0d ins=%0d",
                     cycle_count, instr_count, 16'(exp_cyc), 16'(exp_ins));
         end
      end
`endif
   endtask

   task automatic advance();
      if (rst) begin
         step    = 0;
         halted  = 1'b0;
         exp_cyc = 0;
         exp_ins = 0;
      end else if (!halted) begin
         exp_cyc++;
         if (step == 2) begin
            if (decoded_instruction == I_HALT) begin
               halted = 1'b1;
            end else begin
               exp_ins++;
               cur  = decoded_instruction;
               step = (instr_len(cur) == 3) ? 0 : 3;
            end
         end else if (step == 3) begin
            step = (instr_len(cur) == 4) ? 0 : 4;
         end else if (step == 4) begin
            step = 0;
         end else begin
            step++;
         end
      end
   endtask

   // One clock: drive inputs on the falling edge, compare, then step the model.
   task automatic tick();
      @(negedge clk);
      rst = nx_rst;
      decoded_instruction = (!halted && step >= 3) ? cur : nx_instr;
      zero_op           = nx_z;
      neg_op            = nx_n;
      unsigned_overflow = nx_u;
      signed_overflow   = nx_s;
      #1;
      check_cycle();
      advance();
   endtask

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic do_reset();
      nx_rst = 1'b1;
      tick();
      tick();
      nx_rst = 1'b0;
   endtask

   // Run to the DECODE cycle and present instruction i there.
   task automatic go_decode(decoded_instruction_type i);
      nx_instr = I_NOP;
      for (int k = 0; k < 10 && !(step == 2 && !halted); k++) tick();
      nx_instr = i;
      tick();
   endtask

   initial begin
      do_reset();
      chk("rst_halt", 32'(halt), 0);
      chk("rst_addr_sel", 32'(addr_sel), 0);
      tick();
      chk("fetch_addr_sel", 32'(addr_sel), 1);
      chk("fetch_ir_en", 32'(ir_enable), 0);
      tick();
      chk("fetch_ir_ir_en", 32'(ir_enable), 1);
      nx_instr = I_NOP;
      tick();
      chk("nop_pc_en", 32'(pc_enable), 1);
      chk("nop_branch", 32'(branch), 0);
      tick();
      chk("nop_back_fetch", 32'({addr_sel, ir_enable}), 32'b10);

      go_decode(I_ADD);
      chk("add_pc_en", 32'(pc_enable), 1);
      tick();
      chk("add_op", 32'(operation), 1);
      chk("add_strobes", 32'({c_sel, write_reg_enable, flags_reg_enable}), 32'b111);
      go_decode(I_MOVE);
      tick();
      chk("move_op", 32'(operation), 0);
      chk("move_flags_en", 32'(flags_reg_enable), 0);
      chk("move_wr_reg", 32'(write_reg_enable), 1);

      nx_z = 1'b1;
      go_decode(I_BZERO);
      chk("bzero_taken", 32'({pc_enable, branch}), 32'b11);
      nx_z = 1'b0;
      go_decode(I_BZERO);
      chk("bzero_not_taken", 32'({pc_enable, branch}), 32'b10);
      nx_s = 1'b1;
      go_decode(I_BNOV);
      chk("bnov_ov_set", 32'(branch), 0);
      nx_s = 1'b0;

      go_decode(I_LOAD);
      tick();
      chk("load_addr_sel", 32'(addr_sel), 0);
      chk("load_addr_no_wr", 32'(write_reg_enable), 0);
      tick();
      chk("load_wb", 32'({c_sel, write_reg_enable}), 32'b01);
      go_decode(I_STORE);
      tick();
      chk("store_we", 32'({ram_write_enable, addr_sel}), 32'b10);

      go_decode(I_HALT);
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("halt_held", 32'({halt, pc_enable}), 32'b10);
      end
      nx_rst = 1'b1;
      tick();
      chk("halt_cleared", 32'(halt), 0);
      tick();
      nx_rst = 1'b0;
      tick();
      chk("post_halt_fetch", 32'(addr_sel), 1);

      go_decode(I_LOAD);
      nx_rst = 1'b1;
      tick();
      chk("abort_load_wr", 32'(write_reg_enable), 0);
      nx_rst = 1'b0;
      tick();
      chk("abort_load_fetch", 32'({addr_sel, write_reg_enable}), 32'b10);

      do_reset();
      nx_instr = I_NOP;
      for (int k = 0; k < 9; k++) tick();
      tick();
`ifdef CONTROL_UNIT_PERF_EN
      chk("perf_cycles", 32'(cycle_count), 9);
      chk("perf_instrs", 32'(instr_count), 3);
`endif

      for (int c = 0; c < 4000; c++) begin
         nx_rst = ($urandom_range(0, 99) == 0) || (halted && $urandom_range(0, 9) == 0);
         if (step == 2 && $urandom_range(0, 99) < 3) begin
            nx_instr = I_HALT;
         end else begin
            nx_instr = decoded_instruction_type'(5'($urandom_range(0, 31)));
         end
         {nx_z, nx_n, nx_u, nx_s} = 4'($urandom_range(0, 15));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
